// File: rtl/fetch_pkg.sv
// Shared types for the fetch front-end: FSM states, FIFO entry layout and PC step helper.
// Holds no logic, so it has no latency and no backpressure of its own.
package fetch_pkg;

  localparam int PKG_ADDR_W  = 32;
  localparam int PKG_INSTR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DRAIN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [PKG_ADDR_W-1:0]  pc;
    logic [PKG_INSTR_W-1:0] word;
  } fetch_entry_t;

  function automatic int unsigned pc_step(input int unsigned instr_w);
    return instr_w / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with a flush: the head is read from registered storage, one cycle after the push edge.
// A push is dropped when the FIFO is full and not popping, a pop is dropped when empty, and a flush beats both.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   head_valid,
  output logic [WIDTH-1:0]       head_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop     = pop && (count != '0);
  assign do_push    = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front-end: run/stop FSM, single-outstanding memory port, prefetch FIFO, redirect and halt.
// Best cadence is one word per two cycles with 1-cycle memory; requests stop while the FIFO is full.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 DEPTH     = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] HALT_WORD = 32'hEF00_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  output logic               busy,
  output logic               halted
);

  localparam int unsigned STEP  = pc_step(INSTR_W);
  localparam int          CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] word;
  } entry_t;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_pc_nxt;
  logic [ADDR_W-1:0] align_mask;
  logic [CNT_W-1:0]  count;
  logic              handshake;
  logic              redirect;
  logic              push;
  logic              flush;
  entry_t            push_ent;
  entry_t            head_ent;

  assign align_mask = ~ADDR_W'(STEP - 1);
  assign busy       = (state == FETCH) || (state == WAIT) || (state == DRAIN);
  assign halted     = (state == HALTED);
  assign redirect   = branch_valid && busy;
  // Only one request is ever in flight, so count < DEPTH reserves the slot its response needs.
  assign imem_req   = (state == FETCH) && (count < CNT_W'(DEPTH));
  assign handshake  = imem_req && imem_ready;
  assign imem_addr  = pc;

  assign push_ent.pc   = req_pc;
  assign push_ent.word = imem_rdata;
  assign instr         = head_ent.word;
  assign instr_pc      = head_ent.pc;

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    req_pc_nxt = req_pc;
    push       = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          pc_nxt    = RESET_PC;
        end
      end
      FETCH: begin
        if (handshake) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + ADDR_W'(STEP);
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          push      = 1'b1;
          state_nxt = (imem_rdata == HALT_WORD) ? HALTED : FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_nxt = FETCH;
      end
      HALTED: begin
        if (start) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase

    // A redirect waits in DRAIN whenever a response is still owed to the old stream.
    if (redirect) begin
      flush  = 1'b1;
      push   = 1'b0;
      pc_nxt = branch_target & align_mask;
      if ((state == FETCH && handshake) || (state != FETCH && !imem_rvalid)) begin
        state_nxt = DRAIN;
      end else begin
        state_nxt = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      req_pc <= req_pc_nxt;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_ent),
    .pop        (instr_ready),
    .flush      (flush),
    .count      (count),
    .head_valid (instr_valid),
    .head_data  (head_ent)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: scenario tasks plus a randomized stream checked against a program-order model.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  localparam logic [31:0] HALT = 32'hEF00_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        busy;
  logic        halted;

  int checks   = 0;
  int failures = 0;

  logic [31:0] halt_addr;
  int          mem_lat;
  bit          mem_rand;
  bit          mem_ready_rand;
  bit          mem_clear;
  int          resp_cnt;
  logic [31:0] resp_addr;
  logic [31:0] req_log[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .busy          (busy),
    .halted        (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == halt_addr) ? HALT : (a ^ 32'h1357_9BDF);
  endfunction

  // Memory model: decides at the negedge what the next posedge will see.
  initial begin
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    resp_cnt    = 0;
    resp_addr   = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (mem_clear) resp_cnt = 0;
      if (resp_cnt == 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(resp_addr);
        resp_cnt    = 0;
      end else if (resp_cnt > 1) begin
        resp_cnt--;
      end
      imem_ready = mem_ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (imem_req === 1'b1 && imem_ready) begin
        req_log.push_back(imem_addr);
        resp_addr = imem_addr;
        resp_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; branch_valid = 1'b0; branch_target = '0;
    instr_ready = 1'b0; mem_clear = 1'b1;
    step();
    rst = 1'b0; mem_clear = 1'b0; req_log.delete();
    halt_addr = 32'hFFFF_FFFF; mem_rand = 1'b0; mem_ready_rand = 1'b0; mem_lat = 1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({imem_req, instr_valid, busy, halted} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got req/valid/busy/halted=%b exp=0000", {imem_req, instr_valid, busy, halted});
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_imem_addr got=%h exp=00000000", imem_addr);
    end
    checks++;
    if (instr !== 32'h0 || instr_pc !== 32'h0) begin
      failures++; $display("FAIL reset_head got instr=%h pc=%h exp=0/0", instr, instr_pc);
    end
  endtask

  task automatic test_sequential();
    int first_c = -1;
    logic [31:0] first_pc = '0;
    logic [31:0] first_word = '0;
    do_reset();
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start = 1'b0;
      if (instr_valid && first_c < 0) begin
        first_c = c; first_pc = instr_pc; first_word = instr;
      end
    end
    checks++;
    if (first_c < 1 || first_c > 4) begin
      failures++; $display("FAIL seq_valid_latency got=%0d exp=1..4", first_c);
    end
    checks++;
    if (first_pc !== 32'h0 || first_word !== mem_word(32'h0)) begin
      failures++; $display("FAIL seq_first_entry got pc=%h w=%h exp pc=0 w=%h", first_pc, first_word, mem_word(32'h0));
    end
    checks++;
    if (req_log.size() < 3 || req_log[0] !== 32'h0 || req_log[1] !== 32'h4 || req_log[2] !== 32'h8) begin
      failures++; $display("FAIL seq_req_addrs got n=%0d exp 0,4,8 first", req_log.size());
    end
  endtask

  task automatic test_fill();
    logic [31:0] exp_pc;
    repeat (10) step();
    checks++;
    if (req_log.size() != 4 || imem_req !== 1'b0 || instr_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL fill_stall got reqs=%0d req=%b exp reqs=4 req=0", req_log.size(), imem_req);
    end
    instr_ready = 1'b1;
    checks++;
    if (instr_pc !== 32'h0) begin
      failures++; $display("FAIL fill_pop_head got=%h exp=00000000", instr_pc);
    end
    step();
    instr_ready = 1'b0;
    repeat (6) step();
    checks++;
    if (req_log.size() != 5 || req_log[req_log.size()-1] !== 32'h10) begin
      failures++; $display("FAIL fill_refill got reqs=%0d exp 5 ending 00000010", req_log.size());
    end
    exp_pc = 32'h4;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        failures++; $display("FAIL fill_order got v=%b pc=%h exp pc=%h", instr_valid, instr_pc, exp_pc);
      end
      exp_pc += 32'h4;
      step();
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    mem_lat = 3; start = 1'b1;
    for (int i = 0; i < 30 && req_log.size() < 2; i++) step();
    start = 1'b0;
    step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      failures++; $display("FAIL br_pre_head got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc);
    end
    branch_valid = 1'b1; branch_target = 32'h103;
    step();
    branch_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      failures++; $display("FAIL br_drain got busy=%b req=%b v=%b exp 1/0/0", busy, imem_req, instr_valid);
    end
    for (int i = 0; i < 20 && req_log.size() < 3; i++) step();
    checks++;
    if (req_log.size() < 3 || req_log[2] !== 32'h100) begin
      failures++; $display("FAIL br_target_req got n=%0d exp third req 00000100", req_log.size());
    end
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== mem_word(32'h100)) begin
      failures++; $display("FAIL br_first_entry got v=%b pc=%h w=%h exp pc=00000100", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_halt();
    logic [31:0] exp_pc;
    do_reset();
    halt_addr = 32'h8; start = 1'b1;
    step();
    start = 1'b0;
    repeat (15) step();
    checks++;
    if (halted !== 1'b1 || busy !== 1'b0 || imem_req !== 1'b0 || req_log.size() != 3) begin
      failures++; $display("FAIL halt_stop got halted=%b busy=%b reqs=%0d exp 1/0/3", halted, busy, req_log.size());
    end
    branch_valid = 1'b1; branch_target = 32'h200;
    step();
    branch_valid = 1'b0;
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b1) begin
      failures++; $display("FAIL halt_branch_ignored got halted=%b v=%b exp 1/1", halted, instr_valid);
    end
    exp_pc = 32'h0;
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
        failures++; $display("FAIL halt_pop got pc=%h w=%h exp pc=%h w=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
      end
      exp_pc += 32'h4;
      step();
    end
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL halt_empty got v=%b exp 0", instr_valid);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 10 && req_log.size() < 4; i++) step();
    checks++;
    if (req_log.size() < 4 || req_log[3] !== 32'hC) begin
      failures++; $display("FAIL halt_resume got n=%0d exp fourth req 0000000c", req_log.size());
    end
  endtask

  task automatic test_wrap_pushpop();
    logic [31:0] exp_list[3];
    bit seen = 1'b0;
    int n;
    exp_list[0] = 32'hFFFF_FFFC; exp_list[1] = 32'h0; exp_list[2] = 32'h4;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && req_log.size() < 2; i++) step();
    branch_valid = 1'b1; branch_target = 32'hFFFF_FFF8; halt_addr = 32'h4;
    step();
    branch_valid = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (imem_rvalid && imem_rdata == mem_word(32'h0) && instr_valid) seen = 1'b1;
      else step();
    end
    checks++;
    if (!seen || instr_pc !== 32'hFFFF_FFF8) begin
      failures++; $display("FAIL wrap_head got seen=%b pc=%h exp pc=fffffff8", seen, instr_pc);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC) begin
      failures++; $display("FAIL pushpop_head got v=%b pc=%h exp pc=fffffffc", instr_valid, instr_pc);
    end
    repeat (10) step();
    n = req_log.size();
    checks++;
    if (n < 4 || req_log[n-4] !== 32'hFFFF_FFF8 || req_log[n-3] !== 32'hFFFF_FFFC ||
        req_log[n-2] !== 32'h0 || req_log[n-1] !== 32'h4 || halted !== 1'b1) begin
      failures++; $display("FAIL wrap_reqs got n=%0d halted=%b exp ...fff8,fffc,0,4 halted", n, halted);
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_list[i] || instr !== mem_word(exp_list[i])) begin
        failures++; $display("FAIL pushpop_order got v=%b pc=%h exp pc=%h", instr_valid, instr_pc, exp_list[i]);
      end
      step();
    end
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL pushpop_count got v=%b exp 0 after three pops", instr_valid);
    end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    mem_lat = 2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && req_log.size() < 1; i++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (imem_rvalid !== 1'b1) begin
      failures++; $display("FAIL rstwait_late_rvalid got=%b exp 1", imem_rvalid);
    end
    step();
    checks++;
    if ({imem_req, instr_valid, busy, halted} !== 4'b0000 || imem_addr !== 32'h0) begin
      failures++; $display("FAIL rstwait_idle got flags=%b addr=%h exp 0000/0", {imem_req, instr_valid, busy, halted}, imem_addr);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem_word(32'h0)) begin
      failures++; $display("FAIL rstwait_restart got v=%b pc=%h exp pc=0", instr_valid, instr_pc);
    end
  endtask

  task automatic test_random_stream();
    logic [31:0] exp_pc = 32'h0;
    int pops = 0;
    do_reset();
    mem_rand = 1'b1; mem_ready_rand = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit br;
      br = ($urandom_range(0, 39) == 0);
      instr_ready  = ($urandom_range(0, 1) == 1);
      branch_valid = br;
      if (br) begin
        branch_target = $urandom;
        exp_pc = branch_target & 32'hFFFF_FFFC;
      end else if (instr_valid && instr_ready) begin
        checks++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          failures++; $display("FAIL rand_pop got pc=%h w=%h exp pc=%h w=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 32'h4;
        pops++;
      end
      step();
    end
    branch_valid = 1'b0; instr_ready = 1'b0;
    checks++;
    if (pops < 50) begin
      failures++; $display("FAIL rand_throughput got pops=%0d exp >=50", pops);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
    halt_addr = 32'hFFFF_FFFF; mem_lat = 1; mem_rand = 1'b0; mem_ready_rand = 1'b0; mem_clear = 1'b0;
    test_reset();
    test_sequential();
    test_fill();
    test_branch();
    test_halt();
    test_wrap_pushpop();
    test_reset_in_wait();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
